apu_dispatch: RTL and testbench
===============================

APU_DISPATCH -- requirements
Module: apu_dispatch

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of accelerator channels, 1..8.
REQ-002 SHALL have parameter CH_LSB, default 3: LSB of the channel-select field inside apu_op_i.
REQ-003 SHALL have parameters WOP=6, WFLAGS=15 and WRFLAGS=5: op, request-flag and response-flag widths.
REQ-004 SHALL derive CW = max(1, clog2(NUM_CH)) as the channel-select field width.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port apu_req_i, input, 1: core request.
REQ-008 SHALL have port apu_gnt_o, output, 1: request accepted.
REQ-009 SHALL have port apu_operands_i, input, 3x32: operand bus.
REQ-010 SHALL have port apu_op_i, input, WOP: operation code.
REQ-011 SHALL have port apu_flags_i, input, WFLAGS: request flags.
REQ-012 SHALL have port apu_rvalid_o, output, 1: response valid.
REQ-013 SHALL have ports apu_result_o, output, 32, and apu_flags_o, output, WRFLAGS: response payload.
REQ-014 SHALL have port ch_req_o, output, NUM_CH: per-channel request.
REQ-015 SHALL have port ch_gnt_i, input, NUM_CH: per-channel grant.
REQ-016 SHALL have ports ch_operands_o (3x32), ch_op_o (WOP) and ch_flags_o (WFLAGS), outputs: shared broadcast of the core inputs.
REQ-017 SHALL have ports ch_rvalid_i (NUM_CH), ch_result_i (NUM_CH x 32) and ch_rflags_i (NUM_CH x WRFLAGS), inputs: per-channel responses.
REQ-018 SHALL have port busy_o, output, 1: any request outstanding.
REQ-019 SHALL have port proto_err_o, output, 1: sticky protocol error.

Function
REQ-020 SHALL compute the target channel tgt = apu_op_i[CH_LSB +: CW]; tgt >= NUM_CH is an illegal target.
REQ-021 SHALL treat a channel as idle when it has no outstanding request, and SHALL allow at most one outstanding request per channel.
REQ-022 SHALL drive ch_req_o[c] = apu_req_i && tgt==c && channel c idle, combinationally.
REQ-023 SHALL drive apu_gnt_o = apu_req_i && ch_gnt_i[tgt] && channel tgt idle for a legal target, combinationally.
REQ-024 SHALL drive apu_gnt_o = apu_req_i && error-slot free for an illegal target, with every ch_req_o held 0.
REQ-025 SHALL, on a granted request, push the tag (tgt, or ERR for an illegal target) into an in-order tag FIFO of depth NUM_CH+1, and mark the channel or error slot busy.
REQ-026 SHALL capture ch_rvalid_i[c] with its result and flags into a 1-entry per-channel holding buffer when channel c is outstanding.
REQ-027 SHALL return responses strictly in grant order.
REQ-028 SHALL drive apu_rvalid_o = FIFO not empty && holding buffer of the head tag valid, combinationally from registers, giving minimum latency of 1 cycle after ch_rvalid_i.
REQ-029 SHALL drive apu_result_o and apu_flags_o from the head buffer while apu_rvalid_o=1, and 0 otherwise.
REQ-030 SHALL return an ERR tag as result 0, flags 1 (bit0 set), with apu_rvalid_o 1 cycle after the grant if ERR is the head tag.
REQ-031 SHALL, in a cycle with apu_rvalid_o=1, pop the FIFO, clear that buffer and mark that channel idle at the clock edge.
REQ-032 SHALL make the freed channel grantable from the following cycle, not the same cycle.
REQ-033 SHALL support FIFO push and pop in the same cycle.
REQ-034 SHALL allow a channel to respond out of turn; its response waits in its buffer until its tag reaches the head.
REQ-035 SHALL ignore ch_rvalid_i[c] for a non-outstanding channel or a full buffer, and SHALL set proto_err_o, which stays set until reset.
REQ-036 SHALL drive busy_o = FIFO not empty.

Reset
REQ-037 SHALL, with rst_i=1 at a rising edge, empty the FIFO, clear all buffers and busy marks and clear proto_err_o; any in-flight requests are discarded.
REQ-038 SHALL hold outputs during and after reset at apu_rvalid_o=0, apu_result_o=0, apu_flags_o=0, busy_o=0, proto_err_o=0; apu_gnt_o and ch_req_o then follow inputs combinationally.
REQ-039 SHALL set proto_err_o on a channel response that arrives after reset for a request discarded by reset.

Verification
REQ-040 SHALL be checked by this scenario: NUM_CH=2, op tgt=1, ch_gnt_i=2'b10, ch1 rvalid 3 cycles later with result 0xDEADBEEF -> apu_gnt_o same cycle, apu_rvalid_o 1 cycle after ch rvalid, result 0xDEADBEEF.
REQ-041 SHALL be checked by this scenario: requests to ch0 then ch1; ch1 responds first (0x11), ch0 later (0x22) -> core sees 0x22 then 0x11.
REQ-042 SHALL be checked by this scenario: second request to busy ch0 -> apu_gnt_o=0 and ch_req_o[0]=0 until the cycle after ch0's response pops.
REQ-043 SHALL be checked by this scenario: NUM_CH=3, op tgt=3 -> immediate grant, no ch_req_o, next cycle apu_rvalid_o=1, result 0, flags 1.
REQ-044 SHALL be checked by this scenario: ch0 rvalid with nothing outstanding -> no apu_rvalid_o, proto_err_o=1 until rst_i.
REQ-045 SHALL be checked by this scenario: rst_i asserted with 2 requests outstanding, then a late ch response -> after reset busy_o=0, no apu_rvalid_o, proto_err_o=1.

Source files
------------

// File: rtl/apu_dispatch.sv
// -----------------------------------------------------------------------------
// apu_dispatch
//
// Routes core APU requests to one of NUM_CH accelerator channels and returns
// the responses to the core strictly in grant order.
//
// Each channel may hold at most one outstanding request. A channel response is
// parked in a one-entry holding buffer until that channel's tag reaches the
// head of the in-order tag FIFO. Requests whose channel-select field names a
// channel that does not exist are accepted into a single error slot. They are
// answered in order with result 0 and flags 1.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   apu_req_i/apu_gnt_o  core request handshake (grant is combinational)
//   apu_operands_i, apu_op_i, apu_flags_i
//                        core request payload, broadcast on ch_* outputs
//   apu_rvalid_o, apu_result_o, apu_flags_o
//                        in-order response to the core (zero when not valid)
//   ch_req_o/ch_gnt_i    per-channel request handshake
//   ch_operands_o, ch_op_o, ch_flags_o
//                        shared copy of the core request payload
//   ch_rvalid_i, ch_result_i, ch_rflags_i
//                        per-channel responses
//   busy_o               at least one request is outstanding
//   proto_err_o          sticky: a channel responded when it was not allowed to
// -----------------------------------------------------------------------------
module apu_dispatch #(
    parameter int NUM_CH  = 2,
    parameter int CH_LSB  = 3,
    parameter int WOP     = 6,
    parameter int WFLAGS  = 15,
    parameter int WRFLAGS = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           apu_req_i,
    output logic                           apu_gnt_o,
    input  logic [2:0][31:0]               apu_operands_i,
    input  logic [WOP-1:0]                 apu_op_i,
    input  logic [WFLAGS-1:0]              apu_flags_i,
    output logic                           apu_rvalid_o,
    output logic [31:0]                    apu_result_o,
    output logic [WRFLAGS-1:0]             apu_flags_o,
    output logic [NUM_CH-1:0]              ch_req_o,
    input  logic [NUM_CH-1:0]              ch_gnt_i,
    output logic [2:0][31:0]               ch_operands_o,
    output logic [WOP-1:0]                 ch_op_o,
    output logic [WFLAGS-1:0]              ch_flags_o,
    input  logic [NUM_CH-1:0]              ch_rvalid_i,
    input  logic [NUM_CH-1:0][31:0]        ch_result_i,
    input  logic [NUM_CH-1:0][WRFLAGS-1:0] ch_rflags_i,
    output logic                           busy_o,
    output logic                           proto_err_o
);

    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // One entry per channel plus one for the error slot, so the FIFO can never
    // overflow.
    localparam int DEPTH = NUM_CH + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CNTW  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          is_err;
        logic [CW-1:0] ch;
    } tag_t;

    logic [CW-1:0]      tgt;
    logic               tgt_legal;

    logic [NUM_CH-1:0]  ch_busy_q, ch_busy_d;
    logic               err_busy_q, err_busy_d;
    logic [NUM_CH-1:0]  buf_valid_q, buf_valid_d;
    logic [31:0]        buf_result_q [NUM_CH];
    logic [WRFLAGS-1:0] buf_flags_q  [NUM_CH];
    logic [NUM_CH-1:0]  capture;
    logic [NUM_CH-1:0]  stray_rsp;
    logic               proto_err_q;

    tag_t               fifo_q [DEPTH];
    logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNTW-1:0]    count_q;

    tag_t               head_tag;
    tag_t               push_tag;
    logic               head_ready;
    logic [31:0]        head_result;
    logic [WRFLAGS-1:0] head_flags;
    logic               push, pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign tgt       = apu_op_i[CH_LSB +: CW];
    assign tgt_legal = (32'(tgt) < 32'(NUM_CH));

    // The request payload is shared by all channels; only ch_req_o selects.
    assign ch_operands_o = apu_operands_i;
    assign ch_op_o       = apu_op_i;
    assign ch_flags_o    = apu_flags_i;

    // Request routing. A busy channel sees no request at all. An illegal
    // target never reaches a channel and is granted by the error slot.
    always_comb begin
        ch_req_o  = '0;
        apu_gnt_o = 1'b0;
        if (apu_req_i) begin
            if (tgt_legal) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (tgt == CW'(c) && !ch_busy_q[c]) begin
                        ch_req_o[c] = 1'b1;
                        apu_gnt_o   = ch_gnt_i[c];
                    end
                end
            end else begin
                apu_gnt_o = !err_busy_q;
            end
        end
    end

    assign push            = apu_gnt_o;
    assign push_tag.is_err = !tgt_legal;
    assign push_tag.ch     = tgt;

    // Head-of-line view. It uses registers only, so the response never depends
    // combinationally on this cycle's channel inputs.
    always_comb begin
        head_tag    = fifo_q[rd_ptr_q];
        head_ready  = head_tag.is_err;
        head_result = '0;
        head_flags  = '0;
        if (head_tag.is_err) begin
            head_flags = WRFLAGS'(1);
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (head_tag.ch == CW'(c)) begin
                    head_ready  = buf_valid_q[c];
                    head_result = buf_result_q[c];
                    head_flags  = buf_flags_q[c];
                end
            end
        end
    end

    assign apu_rvalid_o = (count_q != '0) && head_ready;
    assign apu_result_o = apu_rvalid_o ? head_result : '0;
    assign apu_flags_o  = apu_rvalid_o ? head_flags  : '0;
    assign pop          = apu_rvalid_o;
    assign busy_o       = (count_q != '0);
    assign proto_err_o  = proto_err_q;

    // A response is accepted only while the channel is outstanding and its
    // buffer is empty. Any other response is dropped and flagged.
    always_comb begin
        capture   = '0;
        stray_rsp = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            capture[c]   = ch_rvalid_i[c] && ch_busy_q[c] && !buf_valid_q[c];
            stray_rsp[c] = ch_rvalid_i[c] && !capture[c];
        end
    end

    // Busy and buffer bookkeeping. Push and pop can never touch the same
    // channel in one cycle because a busy channel cannot be granted. The freed
    // channel therefore becomes grantable only from the next cycle.
    always_comb begin
        ch_busy_d   = ch_busy_q;
        buf_valid_d = buf_valid_q | capture;
        err_busy_d  = err_busy_q;
        if (pop) begin
            if (head_tag.is_err) begin
                err_busy_d = 1'b0;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (head_tag.ch == CW'(c)) begin
                        ch_busy_d[c]   = 1'b0;
                        buf_valid_d[c] = 1'b0;
                    end
                end
            end
        end
        if (push) begin
            if (push_tag.is_err) begin
                err_busy_d = 1'b1;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (tgt == CW'(c)) begin
                        ch_busy_d[c] = 1'b1;
                    end
                end
            end
        end
    end

    // Control state. Reset discards everything in flight, so a late response
    // to a discarded request is later seen as stray.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ch_busy_q   <= '0;
            buf_valid_q <= '0;
            err_busy_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            ch_busy_q   <= ch_busy_d;
            buf_valid_q <= buf_valid_d;
            err_busy_q  <= err_busy_d;
            if (push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
            if (|stray_rsp) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Payload storage. It needs no reset because the valid bits and the FIFO
    // count qualify every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_tag;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (capture[c]) begin
                buf_result_q[c] <= ch_result_i[c];
                buf_flags_q[c]  <= ch_rflags_i[c];
            end
        end
    end

endmodule

// File: tb/tb_apu_dispatch.sv
// -----------------------------------------------------------------------------
// tb_apu_dispatch
//
// Testbench for apu_dispatch with two instances:
//   dut  : NUM_CH=3. Directed scenarios and random traffic. Checked against a
//          queue-based model plus a response scoreboard drained by a monitor.
//   dut2 : NUM_CH=2. The basic single-request round trip.
// -----------------------------------------------------------------------------
module tb_apu_dispatch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i;

    // NUM_CH=3 instance
    logic             apu_req_i, apu_gnt_o;
    logic [2:0][31:0] apu_operands_i;
    logic [5:0]       apu_op_i;
    logic [14:0]      apu_flags_i;
    logic             apu_rvalid_o;
    logic [31:0]      apu_result_o;
    logic [4:0]       apu_flags_o;
    logic [2:0]       ch_req_o, ch_gnt_i, ch_rvalid_i;
    logic [2:0][31:0] ch_operands_o;
    logic [5:0]       ch_op_o;
    logic [14:0]      ch_flags_o;
    logic [2:0][31:0] ch_result_i;
    logic [2:0][4:0]  ch_rflags_i;
    logic             busy_o, proto_err_o;

    // NUM_CH=2 instance
    logic             req_b, gnt_o_b, rvalid_b, busy_b, perr_b;
    logic [2:0][31:0] operands_b, ch_operands_b;
    logic [5:0]       op_b, ch_op_b;
    logic [14:0]      flags_i_b, ch_flags_b;
    logic [31:0]      result_b;
    logic [4:0]       flags_b;
    logic [1:0]       chreq_b, gnt_b, rv_b;
    logic [1:0][31:0] res_b;
    logic [1:0][4:0]  rfl_b;

    apu_dispatch #(.NUM_CH(3)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
        .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i),
        .apu_rvalid_o(apu_rvalid_o), .apu_result_o(apu_result_o), .apu_flags_o(apu_flags_o),
        .ch_req_o(ch_req_o), .ch_gnt_i(ch_gnt_i),
        .ch_operands_o(ch_operands_o), .ch_op_o(ch_op_o), .ch_flags_o(ch_flags_o),
        .ch_rvalid_i(ch_rvalid_i), .ch_result_i(ch_result_i), .ch_rflags_i(ch_rflags_i),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    apu_dispatch #(.NUM_CH(2)) dut2 (
        .clk_i(clk), .rst_i(rst_i),
        .apu_req_i(req_b), .apu_gnt_o(gnt_o_b),
        .apu_operands_i(operands_b), .apu_op_i(op_b), .apu_flags_i(flags_i_b),
        .apu_rvalid_o(rvalid_b), .apu_result_o(result_b), .apu_flags_o(flags_b),
        .ch_req_o(chreq_b), .ch_gnt_i(gnt_b),
        .ch_operands_o(ch_operands_b), .ch_op_o(ch_op_b), .ch_flags_o(ch_flags_b),
        .ch_rvalid_i(rv_b), .ch_result_i(res_b), .ch_rflags_i(rfl_b),
        .busy_o(busy_b), .proto_err_o(perr_b)
    );

    // Reference model: grant-order tag queue, per-channel outstanding and
    // arrived flags, error slot, sticky protocol error.
    typedef struct { bit is_err; int ch; } tag_t;
    typedef struct { logic [31:0] res; logic [4:0] flg; } resp_t;

    tag_t        tag_q[$];
    resp_t       exp_q[$];
    bit          m_busy[3];
    bit          m_arrived[3];
    bit          m_err_busy;
    bit          m_proto;
    logic [31:0] plan_res[3];
    logic [4:0]  plan_flg[3];
    int          pend[3];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearModel();
        tag_q.delete();
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            m_busy[c]    = 1'b0;
            m_arrived[c] = 1'b0;
            pend[c]      = 0;
        end
        m_err_busy = 1'b0;
        m_proto    = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_i       = 1'b1;
        apu_req_i   = 1'b0;
        ch_gnt_i    = '0;
        ch_rvalid_i = '0;
        @(posedge clk);
        clearModel();
        @(negedge clk);
        checkOutput("rst_rvalid", 32'(apu_rvalid_o), 32'd0);
        checkOutput("rst_result", apu_result_o, 32'd0);
        checkOutput("rst_flags", 32'(apu_flags_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_proto", 32'(proto_err_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // One clock cycle on the NUM_CH=3 instance. val is the result the target
    // channel will return if this request is granted.
    task automatic applyStimulus(input bit req, input int tgt, input logic [2:0] gnt,
                                 input logic [2:0] rv, input logic [31:0] val);
        logic [5:0]       op;
        logic [2:0][31:0] ops;
        logic [2:0]       exp_req;
        logic             exp_gnt, exp_rv;
        bit               legal;
        @(negedge clk);
        op      = 6'($urandom);
        op[4:3] = 2'(tgt);
        ops     = {$urandom, $urandom, $urandom};
        apu_req_i      = req;
        apu_op_i       = op;
        apu_flags_i    = 15'($urandom);
        apu_operands_i = ops;
        ch_gnt_i       = gnt;
        ch_rvalid_i    = rv;
        for (int c = 0; c < 3; c++) begin
            if (m_busy[c]) begin
                ch_result_i[c] = plan_res[c];
                ch_rflags_i[c] = plan_flg[c];
            end else begin
                ch_result_i[c] = $urandom;
                ch_rflags_i[c] = 5'($urandom);
            end
        end
        #2;
        legal   = (tgt < 3);
        exp_req = '0;
        exp_gnt = 1'b0;
        if (req) begin
            if (legal) begin
                if (!m_busy[tgt]) begin
                    exp_req[tgt] = 1'b1;
                    exp_gnt      = gnt[tgt];
                end
            end else begin
                exp_gnt = !m_err_busy;
            end
        end
        exp_rv = (tag_q.size() != 0) && (tag_q[0].is_err || m_arrived[tag_q[0].ch]);
        checkOutput("apu_gnt", 32'(apu_gnt_o), 32'(exp_gnt));
        checkOutput("ch_req", 32'(ch_req_o), 32'(exp_req));
        checkOutput("apu_rvalid", 32'(apu_rvalid_o), 32'(exp_rv));
        checkOutput("busy", 32'(busy_o), 32'(tag_q.size() != 0));
        checkOutput("proto_err", 32'(proto_err_o), 32'(m_proto));
        checkOutput("ch_op", 32'(ch_op_o), 32'(op));
        checkOutput("ch_operand2", ch_operands_o[2], ops[2]);
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            if (rv[c]) begin
                if (m_busy[c] && !m_arrived[c]) m_arrived[c] = 1'b1;
                else                            m_proto      = 1'b1;
            end
            if (pend[c] > 0) pend[c]--;
        end
        if (exp_rv) begin
            tag_t t;
            t = tag_q.pop_front();
            if (t.is_err) begin
                m_err_busy = 1'b0;
            end else begin
                m_busy[t.ch]    = 1'b0;
                m_arrived[t.ch] = 1'b0;
            end
        end
        if (exp_gnt) begin
            if (legal) begin
                m_busy[tgt]   = 1'b1;
                plan_res[tgt] = val;
                plan_flg[tgt] = 5'($urandom);
                pend[tgt]     = int'($urandom_range(1, 4));
                tag_q.push_back('{1'b0, tgt});
                exp_q.push_back('{val, plan_flg[tgt]});
            end else begin
                m_err_busy = 1'b1;
                tag_q.push_back('{1'b1, 0});
                exp_q.push_back('{32'h0, 5'h1});
            end
        end
    endtask

    // Scoreboard monitor: every response the DUT presents must match the
    // oldest expected response. Idle payload must read as zero.
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst_i) begin
                if (apu_rvalid_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_rsp: got result 0x%0h, expected no response at %0t",
                                 apu_result_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("rsp_result", apu_result_o, e.res);
                        checkOutput("rsp_flags", 32'(apu_flags_o), 32'(e.flg));
                    end
                end else begin
                    checkOutput("idle_result", apu_result_o, 32'd0);
                    checkOutput("idle_flags", 32'(apu_flags_o), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [2:0] rv;
        int         n;
        rst_i          = 1'b1;
        apu_req_i      = 1'b0;
        apu_op_i       = '0;
        apu_flags_i    = '0;
        apu_operands_i = '0;
        ch_gnt_i       = '0;
        ch_rvalid_i    = '0;
        ch_result_i    = '0;
        ch_rflags_i    = '0;
        req_b          = 1'b0;
        op_b           = '0;
        flags_i_b      = '0;
        operands_b     = '0;
        gnt_b          = '0;
        rv_b           = '0;
        res_b          = '0;
        rfl_b          = '0;
        clearModel();
        applyReset();
        mon_en = 1'b1;

        // NUM_CH=2: request to ch1, response 3 cycles later, rvalid 1 cycle after.
        @(negedge clk);
        req_b = 1'b1; op_b = 6'b001000; gnt_b = 2'b10;
        #2;
        checkOutput("d2_gnt", 32'(gnt_o_b), 32'd1);
        checkOutput("d2_chreq", 32'(chreq_b), 32'd2);
        @(negedge clk);
        req_b = 1'b0; gnt_b = 2'b00;
        #2;
        checkOutput("d2_busy", 32'(busy_b), 32'd1);
        checkOutput("d2_rvalid_w1", 32'(rvalid_b), 32'd0);
        @(negedge clk);
        #2;
        checkOutput("d2_rvalid_w2", 32'(rvalid_b), 32'd0);
        @(negedge clk);
        rv_b = 2'b10; res_b[1] = 32'hDEADBEEF; rfl_b[1] = 5'h0A;
        #2;
        checkOutput("d2_rvalid_w3", 32'(rvalid_b), 32'd0);
        @(negedge clk);
        rv_b = 2'b00;
        #2;
        checkOutput("d2_rvalid", 32'(rvalid_b), 32'd1);
        checkOutput("d2_result", result_b, 32'hDEADBEEF);
        checkOutput("d2_flags", 32'(flags_b), 32'h0A);
        @(negedge clk);
        #2;
        checkOutput("d2_rvalid_after", 32'(rvalid_b), 32'd0);
        checkOutput("d2_busy_after", 32'(busy_b), 32'd0);
        checkOutput("d2_proto", 32'(perr_b), 32'd0);

        // Out-of-order channel responses return in grant order; ch0 is blocked
        // while busy and grantable the cycle after its response pops.
        applyStimulus(1, 0, 3'b001, 3'b000, 32'h22);
        applyStimulus(1, 1, 3'b010, 3'b000, 32'h11);
        applyStimulus(1, 0, 3'b001, 3'b010, 32'h0);
        applyStimulus(1, 0, 3'b001, 3'b000, 32'h0);
        applyStimulus(1, 0, 3'b001, 3'b001, 32'h0);
        applyStimulus(1, 0, 3'b001, 3'b000, 32'h0);
        applyStimulus(1, 0, 3'b001, 3'b000, 32'h33);
        applyStimulus(0, 0, 3'b000, 3'b001, 32'h0);
        applyStimulus(0, 0, 3'b000, 3'b000, 32'h0);
        applyStimulus(0, 0, 3'b000, 3'b000, 32'h0);

        // Illegal target 3: immediate grant, error response next cycle.
        applyStimulus(1, 3, 3'b000, 3'b000, 32'h0);
        applyStimulus(1, 3, 3'b000, 3'b000, 32'h0);
        applyStimulus(1, 3, 3'b111, 3'b000, 32'h0);
        applyStimulus(0, 0, 3'b000, 3'b000, 32'h0);
        applyStimulus(0, 0, 3'b000, 3'b000, 32'h0);

        // Stray response: sticky protocol error until reset.
        applyStimulus(0, 0, 3'b000, 3'b001, 32'h0);
        repeat (3) applyStimulus(0, 0, 3'b000, 3'b000, 32'h0);
        applyReset();
        applyStimulus(0, 0, 3'b000, 3'b000, 32'h0);

        // Reset with two requests outstanding, then late responses.
        applyStimulus(1, 0, 3'b001, 3'b000, 32'h5);
        applyStimulus(1, 1, 3'b010, 3'b000, 32'h6);
        applyReset();
        applyStimulus(0, 0, 3'b000, 3'b011, 32'h0);
        applyStimulus(0, 0, 3'b000, 3'b000, 32'h0);
        applyStimulus(0, 0, 3'b000, 3'b000, 32'h0);

        // Random traffic.
        applyReset();
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 3; c++) rv[c] = (pend[c] == 1);
            applyStimulus($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2)),
                          3'($urandom), rv, $urandom);
        end

        // Drain outstanding work with a bounded cycle budget.
        n = 0;
        while (tag_q.size() != 0 && n < 60) begin
            for (int c = 0; c < 3; c++) rv[c] = (pend[c] == 1);
            applyStimulus(0, 0, 3'b000, rv, 32'h0);
            n++;
        end
        checks++;
        if (tag_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout: %0d tags still outstanding, expected 0", tag_q.size());
        end
        applyStimulus(0, 0, 3'b000, 3'b000, 32'h0);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
